// File: rtl/param_alu_pipe_if.sv
// Operand/result handshake bundle for param_alu_pipe.
// The slave modport is the ALU's view; the master modport is the source/sink side.
interface param_alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             acc_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             ovf;
  logic             parity;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, a, b, cin, acc_sel, out_ready,
    input  in_ready, out_valid, result, carry, zero, ovf, parity, acc
  );

  modport slave (
    input  in_valid, op, a, b, cin, acc_sel, out_ready,
    output in_ready, out_valid, result, carry, zero, ovf, parity, acc
  );
endinterface

// File: rtl/param_alu_pipe.sv
// Two-stage pipelined ALU with flags and an optional accumulator.
// S1 holds the operand beat; S2 holds the registered result and flags.
module param_alu_pipe #(
  parameter int WIDTH  = 8,
  parameter bit ACC_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  param_alu_pipe_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_XNOR   = 4'd5,
    OP_SHL    = 4'd6,
    OP_SHR    = 4'd7,
    OP_PASSA  = 4'd8,
    OP_PASSB  = 4'd9,
    OP_CMP    = 4'd10,
    OP_NOTA   = 4'd11,
    OP_INC    = 4'd12,
    OP_DEC    = 4'd13,
    OP_RSVD   = 4'd14,
    OP_CLRACC = 4'd15
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic             s1_acc_sel;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic             zero_q;
  logic             ovf_q;
  logic             parity_q;

  logic             s1_adv;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_n;
  logic             carry_n;
  logic             ovf_n;

  assign s1_adv   = s1_valid & (~out_valid_q | bus.out_ready);
  assign in_ready = ~s1_valid | s1_adv;
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_op      <= OP_ADD;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_cin     <= 1'b0;
      s1_acc_sel <= 1'b0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_op      <= op_e'(bus.op);
      s1_a       <= bus.a;
      s1_b       <= bus.b;
      s1_cin     <= bus.cin;
      s1_acc_sel <= bus.acc_sel;
    end else if (s1_adv) begin
      s1_valid   <= 1'b0;
    end
  end

  // All arithmetic ops share one adder; SUB/CMP/DEC feed the inverted or all-ones operand.
  always_comb begin
    opa   = (ACC_EN && s1_acc_sel) ? acc_q : s1_a;
    add_x = opa;
    add_y = s1_b;
    add_c = s1_cin;
    case (s1_op)
      OP_SUB, OP_CMP: begin add_y = ~s1_b; add_c = 1'b1; end
      OP_INC:         begin add_y = '0;    add_c = 1'b1; end
      OP_DEC:         begin add_y = '1;    add_c = 1'b0; end
      default: ;
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};

    res_n   = '0;
    carry_n = 1'b0;
    ovf_n   = 1'b0;
    case (s1_op)
      OP_ADD, OP_SUB, OP_CMP, OP_INC, OP_DEC: begin
        res_n   = sum[WIDTH-1:0];
        carry_n = sum[WIDTH];
        ovf_n   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
      end
      OP_AND:   res_n = opa & s1_b;
      OP_OR:    res_n = opa | s1_b;
      OP_XOR:   res_n = opa ^ s1_b;
      OP_XNOR:  res_n = ~(opa ^ s1_b);
      OP_SHL: begin
        res_n   = {opa[WIDTH-2:0], 1'b0};
        carry_n = opa[WIDTH-1];
      end
      OP_SHR: begin
        res_n   = {1'b0, opa[WIDTH-1:1]};
        carry_n = opa[0];
      end
      OP_PASSA: res_n = opa;
      OP_PASSB: res_n = s1_b;
      OP_NOTA:  res_n = ~opa;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      parity_q    <= 1'b0;
      acc_q       <= '0;
    end else if (s1_adv) begin
      out_valid_q <= 1'b1;
      result_q    <= res_n;
      carry_q     <= carry_n;
      zero_q      <= (res_n == '0);
      ovf_q       <= ovf_n;
      parity_q    <= ^res_n;
      // CMP and the reserved code are pure flag/result ops; acc stays put.
      if (ACC_EN) begin
        if (s1_op == OP_CLRACC)
          acc_q <= '0;
        else if (s1_op != OP_CMP && s1_op != OP_RSVD)
          acc_q <= res_n;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.parity    = parity_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_param_alu_pipe.sv
// Scoreboard bench for param_alu_pipe: 8-bit and 16-bit instances checked
// against an arithmetic reference model through per-instance expected queues.
module tb_param_alu_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_alu_pipe_if #(.WIDTH(8))  b8();
  param_alu_pipe_if #(.WIDTH(16)) b16();

  param_alu_pipe #(.WIDTH(8), .ACC_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .bus(b8)
  );
  param_alu_pipe #(.WIDTH(16), .ACC_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .bus(b16)
  );

  typedef struct {
    longint res;
    bit     c;
    bit     z;
    bit     v;
    bit     p;
    longint acc;
  } exp_t;

  exp_t   q8[$];
  exp_t   q16[$];
  exp_t   mon8_e;
  exp_t   mon16_e;
  longint macc8;
  longint macc16;
  int     acc8_cnt;
  int     total;
  int     bad;
  bit     rnd_done;

  function automatic void chk(string nm, longint act, longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endfunction

  // Reference behaviour from plain signed/unsigned arithmetic on wide integers.
  function automatic exp_t model(int w, int op, longint a, longint b, bit cin, bit sel, longint accin);
    exp_t   e;
    longint one = 1;
    longint m   = (one << w) - 1;
    longint hi  = (one << (w - 1)) - 1;
    longint lo  = -(one << (w - 1));
    longint A   = sel ? accin : a;
    longint sa  = (A > hi) ? A - (one << w) : A;
    longint sb  = (b > hi) ? b - (one << w) : b;
    longint s;
    longint r   = 0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      0: begin
        r = (A + b + longint'(cin)) & m;
        e.c = ((A + b + longint'(cin)) > m);
        s = sa + sb + longint'(cin);
        e.v = (s > hi) || (s < lo);
      end
      1, 10: begin
        r = (A - b) & m;
        e.c = (A >= b);
        s = sa - sb;
        e.v = (s > hi) || (s < lo);
      end
      2: r = A & b;
      3: r = A | b;
      4: r = A ^ b;
      5: r = ~(A ^ b) & m;
      6: begin r = (A << 1) & m; e.c = ((A >> (w - 1)) & 1) != 0; end
      7: begin r = A >> 1;       e.c = (A & 1) != 0; end
      8: r = A;
      9: r = b;
      11: r = ~A & m;
      12: begin
        r = (A + 1) & m;
        e.c = (A == m);
        e.v = (sa + 1) > hi;
      end
      13: begin
        r = (A - 1) & m;
        e.c = (A != 0);
        e.v = (sa - 1) < lo;
      end
      default: r = 0;
    endcase
    e.res = r;
    e.z   = (r == 0);
    e.p   = ^r;
    if (op == 15)                 e.acc = 0;
    else if (op == 10 || op == 14) e.acc = accin;
    else                          e.acc = r;
    return e;
  endfunction

  task automatic send8(int op, longint a, longint b, bit cin, bit sel);
    int   n  = 0;
    bit   ok = 1'b0;
    exp_t e;
    do begin
      @(posedge clk); #1;
      b8.in_valid = 1'b1;
      b8.op       = 4'(op);
      b8.a        = 8'(a);
      b8.b        = 8'(b);
      b8.cin      = cin;
      b8.acc_sel  = sel;
      @(negedge clk);
      ok = b8.in_ready;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      total++; bad++;
      $display("FAIL send8_accept: in_ready stayed 0 for %0d cycles", n);
    end else begin
      e = model(8, op, a, b, cin, sel, macc8);
      macc8 = e.acc;
      q8.push_back(e);
      acc8_cnt++;
    end
  endtask

  task automatic send16(int op, longint a, longint b, bit cin, bit sel);
    int   n  = 0;
    bit   ok = 1'b0;
    exp_t e;
    do begin
      @(posedge clk); #1;
      b16.in_valid = 1'b1;
      b16.op       = 4'(op);
      b16.a        = 16'(a);
      b16.b        = 16'(b);
      b16.cin      = cin;
      b16.acc_sel  = sel;
      @(negedge clk);
      ok = b16.in_ready;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      total++; bad++;
      $display("FAIL send16_accept: in_ready stayed 0 for %0d cycles", n);
    end else begin
      e = model(16, op, a, b, cin, sel, macc16);
      macc16 = e.acc;
      q16.push_back(e);
    end
  endtask

  task automatic idle8();
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
  endtask

  task automatic drain8();
    int n = 0;
    @(posedge clk); #1;
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    while (q8.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain8_empty", longint'(q8.size()), 0);
  endtask

  task automatic drain16();
    int n = 0;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    while (q16.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain16_empty", longint'(q16.size()), 0);
  endtask

  // Monitors peek while stalled (checks hold-stable) and pop on transfer.
  always @(negedge clk) begin
    if (!rst && b8.out_valid) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL out8_unexpected: result %0h with no beat outstanding", b8.result);
      end else begin
        mon8_e = q8[0];
        chk("out8_result", longint'(b8.result), mon8_e.res);
        chk("out8_carry",  longint'(b8.carry),  longint'(mon8_e.c));
        chk("out8_zero",   longint'(b8.zero),   longint'(mon8_e.z));
        chk("out8_ovf",    longint'(b8.ovf),    longint'(mon8_e.v));
        chk("out8_parity", longint'(b8.parity), longint'(mon8_e.p));
        chk("out8_acc",    longint'(b8.acc),    mon8_e.acc);
        if (b8.out_ready) void'(q8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b16.out_valid) begin
      if (q16.size() == 0) begin
        total++; bad++;
        $display("FAIL out16_unexpected: result %0h with no beat outstanding", b16.result);
      end else begin
        mon16_e = q16[0];
        chk("out16_result", longint'(b16.result), mon16_e.res);
        chk("out16_carry",  longint'(b16.carry),  longint'(mon16_e.c));
        chk("out16_zero",   longint'(b16.zero),   longint'(mon16_e.z));
        chk("out16_ovf",    longint'(b16.ovf),    longint'(mon16_e.v));
        chk("out16_parity", longint'(b16.parity), longint'(mon16_e.p));
        chk("out16_acc",    longint'(b16.acc),    mon16_e.acc);
        if (b16.out_ready) void'(q16.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cnt;
    total = 0; bad = 0; macc8 = 0; macc16 = 0; acc8_cnt = 0; rnd_done = 1'b0;
    rst = 1'b1;
    b8.in_valid = 1'b0;  b8.op = '0;  b8.a = '0;  b8.b = '0;  b8.cin = 1'b0;  b8.acc_sel = 1'b0;  b8.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.op = '0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.acc_sel = 1'b0; b16.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", longint'(b8.out_valid), 0);
    chk("rst_in_ready",  longint'(b8.in_ready),  1);
    chk("rst_acc",       longint'(b8.acc),       0);
    chk("rst_result",    longint'(b8.result),    0);
    chk("rst_zero",      longint'(b8.zero),      0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD wrap and exact 2-cycle latency
    send8(0, 'hFF, 'h01, 1'b0, 1'b0);
    idle8();
    @(negedge clk);
    chk("lat_cycle1_out_valid", longint'(b8.out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2_out_valid", longint'(b8.out_valid), 1);
    drain8();

    // SUB overflow, then CMP leaves acc alone
    send8(1, 'h80, 'h01, 1'b0, 1'b0);
    send8(10, 'h05, 'h07, 1'b0, 1'b0);
    drain8();
    chk("cmp_acc_kept", longint'(b8.acc), 'h7F);

    // accumulate chain, back to back
    send8(15, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send8(0, 0, 'h05, 1'b0, 1'b1);
    drain8();
    chk("accum_final", longint'(b8.acc), 'h0F);

    // backpressure: 4 beats against a stalled sink
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    start_cnt = acc8_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send8(int'($urandom_range(0, 13)), longint'($urandom_range(0, 255)),
                longint'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        idle8();
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_in_ready_low", longint'(b8.in_ready), 0);
        chk("bp_accepted",     longint'(acc8_cnt - start_cnt), 2);
        @(posedge clk); #1;
        b8.out_ready = 1'b1;
      end
    join
    drain8();
    chk("bp_all_accepted", longint'(acc8_cnt - start_cnt), 4);

    // reset with two beats in flight
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    send8(0, 'h12, 'h34, 1'b0, 1'b0);
    send8(3, 'h0F, 'hF0, 1'b0, 1'b0);
    @(posedge clk); #1;
    b8.in_valid  = 1'b0;
    rst          = 1'b1;
    b8.out_ready = 1'b1;
    q8.delete();
    q16.delete();
    macc8  = 0;
    macc16 = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", longint'(b8.out_valid), 0);
    chk("midrst_in_ready",  longint'(b8.in_ready),  1);
    chk("midrst_acc",       longint'(b8.acc),       0);
    chk("midrst_result",    longint'(b8.result),    0);
    @(posedge clk); #1;
    rst = 1'b0;
    send8(0, 'h21, 'h10, 1'b1, 1'b0);
    drain8();

    // randomized traffic with random sink stalls
    fork
      begin
        for (int i = 0; i < 300; i++)
          send8(int'($urandom_range(0, 15)), longint'($urandom_range(0, 255)),
                longint'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        idle8();
        rnd_done = 1'b1;
      end
      begin
        for (int k = 0; k < 5000 && !rnd_done; k++) begin
          @(posedge clk); #1;
          b8.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain8();

    // 16-bit instance: shift and increment edge cases, then random
    send16(6, 'h8001, 0, 1'b0, 1'b0);
    send16(12, 'hFFFF, 0, 1'b0, 1'b0);
    send16(12, 'h7FFF, 0, 1'b0, 1'b0);
    send16(13, 'h0000, 0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++)
      send16(int'($urandom_range(0, 15)), longint'($urandom_range(0, 65535)),
             longint'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    drain16();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
